uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; there are no parameters.
REQ-002 clk  input  1  system clock, 100 MHz, all state on rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 load  input  1  single-cycle strobe: request transmission of data_in.
REQ-005 data_in  input  8  character to send, LSB first.
REQ-006 bit8  input  1  1 = 8 data bits, 0 = 7 data bits (D7 ignored).
REQ-007 parity_en  input  1  1 = append a parity bit.
REQ-008 odd_n_even  input  1  1 = odd parity, 0 = even parity.
REQ-009 baud_val  input  4  baud-rate select.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 tx_rdy  output  1  1 = idle, able to accept load.

Function
REQ-012 States SHALL be IDLE and SHIFT only; SHIFT uses a 4-bit bit index (0..10) and a 19-bit baud counter.
REQ-013 load SHALL be accepted only when tx_rdy=1; load with tx_rdy=0 SHALL be ignored with no effect on the frame in progress.
REQ-014 On acceptance, data_in, bit8, parity_en, odd_n_even and baud_val SHALL be captured; input changes during SHIFT SHALL NOT affect the frame.
REQ-015 In the cycle after acceptance, tx SHALL be 0 (start bit) and tx_rdy SHALL be 0; tx SHALL be registered.
REQ-016 Every frame SHALL be exactly 11 bit periods: pos 0 start=0; pos 1..7 = D0..D6; pos 8 = D7 if bit8, else P if parity_en, else 1; pos 9 = P if (bit8 and parity_en), else 1; pos 10 = 1 (stop).
REQ-017 P SHALL be the XOR of the transmitted data bits (7 or 8) XORed with odd_n_even, so the data-plus-parity ones count is odd when odd_n_even=1 and even otherwise.
REQ-018 Bit period in clocks (DIV) by baud_val: 0:333333, 1:83333, 2:41667, 3:20833, 4:10417, 5:5208, 6:2604, 7:1736, 8:868, 9:434, 10:217, 11:109, 12-15:10417.
REQ-019 Each frame position SHALL drive tx for exactly DIV clocks; the baud counter SHALL reset to 0 at each bit boundary and count 0..DIV-1.
REQ-020 After the last clock of pos 10, the block SHALL enter IDLE, with tx=1 and tx_rdy=1 in the following cycle.
REQ-021 A load in the first cycle tx_rdy returns to 1 SHALL be accepted, giving back-to-back frames with exactly one idle-high clock between stop bit and next start bit.
REQ-022 Total frame time SHALL be 11*DIV clocks from the first start-bit clock to the last stop-bit clock.
REQ-023 In IDLE, tx SHALL be held at 1 continuously; no glitches on tx at any bit boundary.

Reset
REQ-024 Asserting reset at any time, including mid-frame, SHALL immediately force tx=1, tx_rdy=1, state=IDLE, and clear counters and captured data.
REQ-025 A load coincident with the clock edge on which reset deasserts SHALL be ignored; the first accepted load is on a later edge.

Verification
REQ-026 baud_val=4, bit8=1, parity_en=0, load 0x41 -> tx = 0,1,0,0,0,0,0,1,0,1,1, each held 10417 clocks; tx_rdy high 114587 clocks after its fall, plus 1.
REQ-027 bit8=1, parity_en=1, odd_n_even=1, baud_val=11, 0x41 -> pos 8 = 0 (D7), pos 9 = P = 1, pos 10 = 1; bit period 109 clocks.
REQ-028 bit8=0, parity_en=1, odd_n_even=0, baud_val=11, 0xC1 -> pos 1..7 = 1,0,0,0,0,0,1; pos 8 = P = 0; pos 9,10 = 1; D7 not sent.
REQ-029 Load 0x55 then 0xAA on the first tx_rdy=1 cycle, baud_val=11 -> two complete frames, one idle clock between; second-frame bits match 0xAA.
REQ-030 Pulse load with 0xFF during pos 3 of a 0x00 frame -> frame continues as 0x00 unchanged; no second frame follows.
REQ-031 Assert reset during pos 5 of a frame -> tx=1 and tx_rdy=1 asynchronously; after release, load 0x41 -> full correct frame from the start bit.

Source files
------------

// File: rtl/uart_tx_engine_if.sv
// Handshake and serial-line bundle between a UART TX client and the engine.
interface uart_tx_engine_if;
    logic       load;
    logic [7:0] data_in;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic [3:0] baud_val;
    logic       tx;
    logic       tx_rdy;

    // Client side: requests frames, observes line and ready
    modport master (
        output load, data_in, bit8, parity_en, odd_n_even, baud_val,
        input  tx, tx_rdy
    );

    // Engine side
    modport slave (
        input  load, data_in, bit8, parity_en, odd_n_even, baud_val,
        output tx, tx_rdy
    );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: fixed 11-position frame (start, 7/8 data, parity/fill, stop)
// with a table-driven baud divider and registered serial output.
module uart_tx_engine (
    input  logic        clk,
    input  logic        reset,
    uart_tx_engine_if.slave bus
);
    localparam int unsigned CNT_W  = 19;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 4;
    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(10);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    bit_idx;
    logic [CNT_W-1:0]    baud_cnt;
    logic [DATA_W-1:0]   data_q;
    logic                bit8_q;
    logic                parity_en_q;
    logic                odd_q;
    logic [SEL_W-1:0]    baud_q;
    logic                tx_q;
    logic                tx_rdy_q;
    logic                armed;

    logic [CNT_W-1:0]    last_cnt_c;
    logic [IDX_W-1:0]    next_idx_c;

    // Bit period in clocks for each baud select code
    function automatic logic [CNT_W-1:0] baud_div(input logic [SEL_W-1:0] sel);
        case (sel)
            4'd0:    baud_div = CNT_W'(333333);
            4'd1:    baud_div = CNT_W'(83333);
            4'd2:    baud_div = CNT_W'(41667);
            4'd3:    baud_div = CNT_W'(20833);
            4'd4:    baud_div = CNT_W'(10417);
            4'd5:    baud_div = CNT_W'(5208);
            4'd6:    baud_div = CNT_W'(2604);
            4'd7:    baud_div = CNT_W'(1736);
            4'd8:    baud_div = CNT_W'(868);
            4'd9:    baud_div = CNT_W'(434);
            4'd10:   baud_div = CNT_W'(217);
            4'd11:   baud_div = CNT_W'(109);
            default: baud_div = CNT_W'(10417);
        endcase
    endfunction

    // Line level for a given frame position; parity covers only the bits actually sent
    function automatic logic frame_bit(
        input logic [IDX_W-1:0]  pos,
        input logic [DATA_W-1:0] d,
        input logic              b8,
        input logic              pe,
        input logic              odd
    );
        logic p;
        p = (^(b8 ? d : {1'b0, d[6:0]})) ^ odd;
        case (pos)
            4'd0:    frame_bit = 1'b0;
            4'd1:    frame_bit = d[0];
            4'd2:    frame_bit = d[1];
            4'd3:    frame_bit = d[2];
            4'd4:    frame_bit = d[3];
            4'd5:    frame_bit = d[4];
            4'd6:    frame_bit = d[5];
            4'd7:    frame_bit = d[6];
            4'd8:    frame_bit = b8 ? d[7] : (pe ? p : 1'b1);
            4'd9:    frame_bit = (b8 && pe) ? p : 1'b1;
            default: frame_bit = 1'b1;
        endcase
    endfunction

    assign last_cnt_c = baud_div(baud_q) - CNT_W'(1);
    assign next_idx_c = bit_idx + IDX_W'(1);

    // Frame sequencer: accept a load in IDLE, then step positions 0..10 every bit period.
    // armed blocks acceptance on the first edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_idx     <= '0;
            baud_cnt    <= '0;
            data_q      <= '0;
            bit8_q      <= 1'b0;
            parity_en_q <= 1'b0;
            odd_q       <= 1'b0;
            baud_q      <= '0;
            tx_q        <= 1'b1;
            tx_rdy_q    <= 1'b1;
            armed       <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    tx_q     <= 1'b1;
                    tx_rdy_q <= 1'b1;
                    if (bus.load && tx_rdy_q && armed) begin
                        data_q      <= bus.data_in;
                        bit8_q      <= bus.bit8;
                        parity_en_q <= bus.parity_en;
                        odd_q       <= bus.odd_n_even;
                        baud_q      <= bus.baud_val;
                        bit_idx     <= '0;
                        baud_cnt    <= '0;
                        tx_q        <= 1'b0;
                        tx_rdy_q    <= 1'b0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (baud_cnt == last_cnt_c) begin
                        baud_cnt <= '0;
                        if (bit_idx == LAST_POS) begin
                            bit_idx  <= '0;
                            tx_q     <= 1'b1;
                            tx_rdy_q <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            bit_idx <= next_idx_c;
                            tx_q    <= frame_bit(next_idx_c, data_q, bit8_q, parity_en_q, odd_q);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx     = tx_q;
    assign bus.tx_rdy = tx_rdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frames are sampled at the first and last
// clock of every position and compared with hand-derived bit patterns.
module tb_uart_tx_engine;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    uart_tx_engine_if bus ();

    uart_tx_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle load; call at a negedge, returns at the first start-bit clock
    task automatic send(input logic [7:0] d, input logic b8, input logic pe,
                        input logic odd, input logic [3:0] baud);
        bus.data_in    = d;
        bus.bit8       = b8;
        bus.parity_en  = pe;
        bus.odd_n_even = odd;
        bus.baud_val   = baud;
        bus.load       = 1'b1;
        @(negedge clk);
        bus.load       = 1'b0;
    endtask

    // Walk one frame; inj_pos >= 0 pulses a conflicting load at that position.
    // Returns on the cycle after the last stop-bit clock.
    task automatic recv(input int div, input int inj_pos,
                        output logic [10:0] first, output logic [10:0] last,
                        output logic busy_ok);
        busy_ok = 1'b1;
        first   = '0;
        last    = '0;
        for (int pos = 0; pos < 11; pos++) begin
            for (int c = 0; c < div; c++) begin
                if (c == 0)       first[pos] = bus.tx;
                if (c == div - 1) last[pos]  = bus.tx;
                if (bus.tx_rdy !== 1'b0) busy_ok = 1'b0;
                if (pos == inj_pos && c == 0) begin
                    bus.data_in   = 8'hFF;
                    bus.bit8      = 1'b0;
                    bus.parity_en = 1'b1;
                    bus.baud_val  = 4'd0;
                    bus.load      = 1'b1;
                end
                if (pos == inj_pos && c == 1) bus.load = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic frame_test(input string tag, input logic [7:0] d, input logic b8,
                              input logic pe, input logic odd, input logic [3:0] baud,
                              input int div, input logic [10:0] exp);
        logic [10:0] f, l;
        logic        ok;
        send(d, b8, pe, odd, baud);
        recv(div, -1, f, l, ok);
        check({tag, "_first"}, 32'(f), 32'(exp));
        check({tag, "_last"},  32'(l), 32'(exp));
        check({tag, "_busy"},  32'(ok), 32'd1);
        check({tag, "_idle"},  {30'd0, bus.tx, bus.tx_rdy}, 32'd3);
    endtask

    initial begin
        logic [10:0] f, l;
        logic        ok;
        int          low_cnt;

        errors         = 0;
        checks         = 0;
        reset          = 1'b1;
        bus.load       = 1'b0;
        bus.data_in    = '0;
        bus.bit8       = 1'b0;
        bus.parity_en  = 1'b0;
        bus.odd_n_even = 1'b0;
        bus.baud_val   = '0;

        repeat (3) @(negedge clk);
        check("reset_state", {30'd0, bus.tx, bus.tx_rdy}, 32'd3);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {30'd0, bus.tx, bus.tx_rdy}, 32'd3);

        // 8N1 'A'
        frame_test("8n_41", 8'h41, 1'b1, 1'b0, 1'b0, 4'd11, 109, 11'b11010000010);
        // 8 bits odd parity: two ones -> P=1
        frame_test("8o_41", 8'h41, 1'b1, 1'b1, 1'b1, 4'd11, 109, 11'b11010000010);
        // 8 bits even parity: P=0 at pos 9
        frame_test("8e_41", 8'h41, 1'b1, 1'b1, 1'b0, 4'd9,  434, 11'b10010000010);
        // 7 bits even parity, D7 dropped: P=0 at pos 8
        frame_test("7e_c1", 8'hC1, 1'b0, 1'b1, 1'b0, 4'd11, 109, 11'b11010000010);
        // 7 bits odd parity: P=1 at pos 8
        frame_test("7o_c1", 8'hC1, 1'b0, 1'b1, 1'b1, 4'd11, 109, 11'b11110000010);
        // 7 bits, no parity: D7 ignored, pos 8 fill = 1
        frame_test("7n_80", 8'h80, 1'b0, 1'b0, 1'b0, 4'd11, 109, 11'b11100000000);
        // 8 bits even parity, all ones: P=0
        frame_test("8e_ff", 8'hFF, 1'b1, 1'b1, 1'b0, 4'd10, 217, 11'b10111111110);

        // Back-to-back: second load on the single idle-high cycle
        send(8'h55, 1'b1, 1'b0, 1'b0, 4'd11);
        recv(109, -1, f, l, ok);
        check("b2b_55", 32'(f & l), 32'(11'b11010101010));
        check("b2b_gap", {30'd0, bus.tx, bus.tx_rdy}, 32'd3);
        send(8'hAA, 1'b1, 1'b0, 1'b0, 4'd11);
        check("b2b_start", {30'd0, bus.tx, bus.tx_rdy}, 32'd0);
        recv(109, -1, f, l, ok);
        check("b2b_aa_first", 32'(f), 32'(11'b11101010100));
        check("b2b_aa_last",  32'(l), 32'(11'b11101010100));

        // Load while busy (pos 3) is ignored and does not queue a frame
        send(8'h00, 1'b1, 1'b0, 1'b0, 4'd11);
        recv(109, 3, f, l, ok);
        check("busy_load_first", 32'(f), 32'(11'b11000000000));
        check("busy_load_last",  32'(l), 32'(11'b11000000000));
        low_cnt = 0;
        for (int i = 0; i < 3 * 109; i++) begin
            if (bus.tx !== 1'b1 || bus.tx_rdy !== 1'b1) low_cnt++;
            @(negedge clk);
        end
        check("busy_load_no_frame", 32'(low_cnt), 32'd0);

        // Reset mid-frame (pos 5) forces idle without waiting for a clock edge
        send(8'h41, 1'b1, 1'b0, 1'b0, 4'd11);
        repeat (5 * 109 + 10) @(negedge clk);
        check("pre_reset_busy", {31'd0, bus.tx_rdy}, 32'd0);
        #1 reset = 1'b1;
        #1 check("async_reset", {30'd0, bus.tx, bus.tx_rdy}, 32'd3);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        frame_test("post_reset_41", 8'h41, 1'b1, 1'b0, 1'b0, 4'd11, 109, 11'b11010000010);

        // Slow rate: start bit lasts exactly 10417 clocks, then D0=1
        send(8'h41, 1'b1, 1'b0, 1'b0, 4'd4);
        f = '0;
        for (int c = 0; c <= 10417; c++) begin
            if (c == 0)     f[0] = bus.tx;
            if (c == 10416) f[1] = bus.tx;
            if (c == 10417) f[2] = bus.tx;
            @(negedge clk);
        end
        check("baud4_start_edges", 32'(f[2:0]), 32'b100);
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("baud4_abort_idle", {30'd0, bus.tx, bus.tx_rdy}, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
